// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flush, memory waits, HLT drain.
// Control outputs are combinational from the registered state and current inputs.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEX_MemRead,
  input  logic [3:0]  IDEX_DstReg,
  input  logic [3:0]  IFID_SrcReg1,
  input  logic [3:0]  IFID_SrcReg2,
  input  logic        IFID_Reg1Used,
  input  logic        IFID_Reg2Used,
  input  logic        BranchTaken,
  input  logic        Halt_ID,
  input  logic        IMem_stall,
  input  logic        DMem_stall,
  output logic        PC_wen,
  output logic        IFID_wen,
  output logic        IFID_flush,
  output logic        IDEX_stall,
  output logic        IDEX_nop,
  output logic        EXMEM_stall,
  output logic        MEMWB_stall,
  output logic [1:0]  state,
  output logic        halt_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    DRAIN    = 2'b10,
    HALTED   = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        load_use;

  assign load_use = IDEX_MemRead && (IDEX_DstReg != 4'h0) &&
                    ((IFID_Reg1Used && (IFID_SrcReg1 == IDEX_DstReg)) ||
                     (IFID_Reg2Used && (IFID_SrcReg2 == IDEX_DstReg)));

  always_comb begin
    PC_wen      = 1'b1;
    IFID_wen    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_stall  = 1'b0;
    IDEX_nop    = 1'b0;
    EXMEM_stall = 1'b0;
    MEMWB_stall = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      RUN: begin
        if (DMem_stall) begin
          PC_wen      = 1'b0;
          IFID_wen    = 1'b0;
          IDEX_stall  = 1'b1;
          EXMEM_stall = 1'b1;
          MEMWB_stall = 1'b1;
          state_d     = MEM_WAIT;
        end else if (load_use) begin
          PC_wen   = 1'b0;
          IFID_wen = 1'b0;
          IDEX_nop = 1'b1;
        end else if (BranchTaken) begin
          // Flushed IF/ID takes a noop instead of the fetched word.
          IFID_wen   = 1'b0;
          IFID_flush = 1'b1;
        end else if (Halt_ID) begin
          PC_wen      = 1'b0;
          IFID_wen    = 1'b0;
          IFID_flush  = 1'b1;
          drain_cnt_d = 2'd3;
          state_d     = DRAIN;
        end else if (IMem_stall) begin
          PC_wen     = 1'b0;
          IFID_wen   = 1'b0;
          IFID_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (DMem_stall) begin
          PC_wen      = 1'b0;
          IFID_wen    = 1'b0;
          IDEX_stall  = 1'b1;
          EXMEM_stall = 1'b1;
          MEMWB_stall = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        PC_wen   = 1'b0;
        IFID_wen = 1'b0;
        IDEX_nop = 1'b1;
        if (DMem_stall) begin
          EXMEM_stall = 1'b1;
          MEMWB_stall = 1'b1;
        end else begin
          drain_cnt_d = (drain_cnt_q == 2'd0) ? 2'd0 : drain_cnt_q - 2'd1;
          if (drain_cnt_d == 2'd0) state_d = HALTED;
        end
      end
      default: begin
        PC_wen   = 1'b0;
        IFID_wen = 1'b0;
        IDEX_nop = 1'b1;
      end
    endcase

    // Reset forces RUN defaults on the outputs regardless of the hazard inputs.
    if (rst) begin
      PC_wen      = 1'b1;
      IFID_wen    = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_stall  = 1'b0;
      IDEX_nop    = 1'b0;
      EXMEM_stall = 1'b0;
      MEMWB_stall = 1'b0;
      state_d     = RUN;
      drain_cnt_d = 2'd0;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (rst) begin
      stall_cycles_d = 16'h0000;
    end else if (((state_q == RUN) || (state_q == MEM_WAIT)) && !PC_wen &&
                 (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      drain_cnt_q    <= 2'd0;
      stall_cycles_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign state        = state_q;
  assign halt_done    = (state_q == HALTED) && !rst;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        IDEX_MemRead;
  logic [3:0]  IDEX_DstReg;
  logic [3:0]  IFID_SrcReg1;
  logic [3:0]  IFID_SrcReg2;
  logic        IFID_Reg1Used;
  logic        IFID_Reg2Used;
  logic        BranchTaken;
  logic        Halt_ID;
  logic        IMem_stall;
  logic        DMem_stall;
  logic        PC_wen;
  logic        IFID_wen;
  logic        IFID_flush;
  logic        IDEX_stall;
  logic        IDEX_nop;
  logic        EXMEM_stall;
  logic        MEMWB_stall;
  logic [1:0]  state;
  logic        halt_done;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] C_DEF    = 7'b1100000;
  localparam logic [6:0] C_LU     = 7'b0000100;
  localparam logic [6:0] C_BR     = 7'b1010000;
  localparam logic [6:0] C_FLUSH  = 7'b0010000;
  localparam logic [6:0] C_DMEM   = 7'b0001011;
  localparam logic [6:0] C_DRAIN  = 7'b0000100;
  localparam logic [6:0] C_DRAINF = 7'b0000111;
  localparam logic [6:0] C_HALT   = 7'b0000100;

  pipeline_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_DstReg   (IDEX_DstReg),
    .IFID_SrcReg1  (IFID_SrcReg1),
    .IFID_SrcReg2  (IFID_SrcReg2),
    .IFID_Reg1Used (IFID_Reg1Used),
    .IFID_Reg2Used (IFID_Reg2Used),
    .BranchTaken   (BranchTaken),
    .Halt_ID       (Halt_ID),
    .IMem_stall    (IMem_stall),
    .DMem_stall    (DMem_stall),
    .PC_wen        (PC_wen),
    .IFID_wen      (IFID_wen),
    .IFID_flush    (IFID_flush),
    .IDEX_stall    (IDEX_stall),
    .IDEX_nop      (IDEX_nop),
    .EXMEM_stall   (EXMEM_stall),
    .MEMWB_stall   (MEMWB_stall),
    .state         (state),
    .halt_done     (halt_done),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control vector order: PC_wen IFID_wen IFID_flush IDEX_stall IDEX_nop EXMEM_stall MEMWB_stall
  task automatic ctl(input string tag, input logic [6:0] exp);
    chk(tag, {9'd0, PC_wen, IFID_wen, IFID_flush, IDEX_stall, IDEX_nop, EXMEM_stall, MEMWB_stall},
        {9'd0, exp});
    chk({tag, "_excl"}, {15'd0, (IDEX_stall & IDEX_nop) | (IFID_wen & IFID_flush)}, 16'd0);
  endtask

  task automatic drive(input logic mr, input logic [3:0] dst, input logic [3:0] s1,
                       input logic [3:0] s2, input logic u1, input logic u2, input logic br,
                       input logic hl, input logic im, input logic dm);
    IDEX_MemRead  = mr;
    IDEX_DstReg   = dst;
    IFID_SrcReg1  = s1;
    IFID_SrcReg2  = s2;
    IFID_Reg1Used = u1;
    IFID_Reg2Used = u2;
    BranchTaken   = br;
    Halt_ID       = hl;
    IMem_stall    = im;
    DMem_stall    = dm;
    #3;
  endtask

  task automatic idle();
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every hazard input active: outputs must show RUN defaults.
    rst = 1'b1;
    drive(1, 4'h3, 4'h3, 4'h3, 1, 1, 1, 1, 1, 1);
    ctl("rst_outputs", C_DEF);
    chk("rst_halt_done", {15'd0, halt_done}, 16'd0);
    cyc();
    chk("rst_state", {14'd0, state}, 16'd0);
    chk("rst_stall_cnt", stall_cycles, 16'd0);

    rst = 1'b0;
    idle();
    ctl("idle_defaults", C_DEF);
    cyc();

    // Load-use on source 2 suppresses the branch.
    drive(1, 4'h3, 4'h0, 4'h3, 0, 1, 1, 0, 0, 0);
    ctl("lu_src2", C_LU);
    cyc();
    chk("lu_state", {14'd0, state}, 16'd0);
    chk("lu_count", stall_cycles, 16'd1);
    drive(0, 4'h3, 4'h0, 4'h3, 0, 1, 0, 0, 0, 0);
    ctl("lu_resume", C_DEF);
    cyc();

    // Destination r0 never hazards; the branch acts.
    drive(1, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0, 0, 0);
    ctl("lu_r0_branch", C_BR);
    cyc();
    chk("lu_r0_count", stall_cycles, 16'd1);

    drive(1, 4'h5, 4'h5, 4'h0, 1, 0, 0, 0, 0, 0);
    ctl("lu_src1", C_LU);
    cyc();
    drive(1, 4'h5, 4'h5, 4'h5, 0, 0, 0, 0, 0, 0);
    ctl("lu_unused_src", C_DEF);
    cyc();
    chk("lu_src1_count", stall_cycles, 16'd2);

    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0);
    ctl("imem_stall", C_FLUSH);
    cyc();
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 1, 0);
    ctl("branch_over_imem", C_BR);
    cyc();
    chk("imem_count", stall_cycles, 16'd3);
    chk("imem_state", {14'd0, state}, 16'd0);

    // Data memory wait: four stalled cycles starting from a clean count.
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1);
    ctl("dmem_run", C_DMEM);
    cyc();
    chk("dmem_state1", {14'd0, state}, 16'd1);
    drive(1, 4'h3, 4'h3, 4'h0, 1, 0, 1, 0, 0, 1);
    ctl("dmem_wait_lu_ignored", C_DMEM);
    cyc();
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 1);
    ctl("dmem_wait_halt_ignored", C_DMEM);
    cyc();
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1);
    ctl("dmem_wait3", C_DMEM);
    cyc();
    chk("dmem_state4", {14'd0, state}, 16'd1);
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 1, 0);
    ctl("dmem_release", C_DEF);
    cyc();
    chk("dmem_back_run", {14'd0, state}, 16'd0);
    chk("dmem_count", stall_cycles, 16'd4);

    // Halt: one RUN cycle, three drain steps with one frozen cycle, then HALTED.
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0);
    ctl("halt_run", C_FLUSH);
    cyc();
    chk("halt_count", stall_cycles, 16'd5);
    chk("drain_state", {14'd0, state}, 16'd2);
    idle();
    ctl("drain1", C_DRAIN);
    cyc();
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1);
    ctl("drain_frozen", C_DRAINF);
    cyc();
    idle();
    ctl("drain2", C_DRAIN);
    cyc();
    chk("drain_still", {14'd0, state}, 16'd2);
    ctl("drain3", C_DRAIN);
    cyc();
    chk("halted_state", {14'd0, state}, 16'd3);
    chk("drain_no_count", stall_cycles, 16'd5);
    drive(1, 4'h3, 4'h3, 4'h3, 1, 1, 1, 1, 1, 1);
    ctl("halted_ignore", C_HALT);
    chk("halt_done", {15'd0, halt_done}, 16'd1);
    cyc();
    cyc();
    chk("halted_sticky", {14'd0, state}, 16'd3);
    ctl("halted_pc_off", C_HALT);
    rst = 1'b1;
    #1;
    ctl("halted_rst_outputs", C_DEF);
    chk("halted_rst_done", {15'd0, halt_done}, 16'd0);
    cyc();
    chk("halted_rst_state", {14'd0, state}, 16'd0);
    chk("halted_rst_count", stall_cycles, 16'd0);

    // Reset in the middle of a memory wait.
    rst = 1'b0;
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1);
    cyc();
    cyc();
    chk("mw_pre_state", {14'd0, state}, 16'd1);
    chk("mw_pre_count", stall_cycles, 16'd2);
    rst = 1'b1;
    #1;
    ctl("mw_rst_outputs", C_DEF);
    cyc();
    chk("mw_rst_state", {14'd0, state}, 16'd0);
    chk("mw_rst_count", stall_cycles, 16'd0);
    rst = 1'b0;
    #1;
    ctl("mw_after_rst_run", C_DMEM);
    cyc();
    chk("mw_reenter", {14'd0, state}, 16'd1);
    chk("mw_reenter_count", stall_cycles, 16'd1);

    // Saturation: 65535 stalled cycles from zero, then two more.
    rst = 1'b1;
    #1;
    cyc();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 65535; i++) cyc();
    chk("sat_reach", stall_cycles, 16'hFFFF);
    cyc();
    cyc();
    chk("sat_hold", stall_cycles, 16'hFFFF);
    chk("sat_state", {14'd0, state}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 (clock); rst in 1 (synchronous, active-high reset); one clock domain only.
REQ-002 SHALL have inputs:
- IDEX_MemRead 1: load in EX.
- IDEX_DstReg 4: destination register of the EX instruction.
- IFID_SrcReg1 4, IFID_SrcReg2 4: source registers of the ID instruction.
- IFID_Reg1Used 1, IFID_Reg2Used 1: the ID instruction reads that source.
- BranchTaken 1: branch resolved taken in ID.
- Halt_ID 1: HLT decoded in ID.
- IMem_stall 1: instruction memory busy.
- DMem_stall 1: data memory busy.
REQ-003 SHALL have pipeline-register control outputs:
- PC_wen 1: PC register write enable.
- IFID_wen 1: IF/ID write enable.
- IFID_flush 1: load a noop into IF/ID.
- IDEX_stall 1: hold ID/EX.
- IDEX_nop 1: load a bubble into ID/EX.
- EXMEM_stall 1, MEMWB_stall 1: hold those registers.
REQ-004 SHALL have status outputs:
- state 2: current FSM state.
- halt_done 1: pipeline drained after HLT.
- stall_cycles 16: saturating count of stalled cycles.

Function
REQ-005 SHALL implement an FSM with states RUN=2'b00, MEM_WAIT=2'b01, DRAIN=2'b10, HALTED=2'b11; the state is registered, and all control outputs are combinational from the state and the current-cycle inputs.
REQ-006 Load-use hazard (LU) SHALL be defined as: IDEX_MemRead=1, IDEX_DstReg!=0, and either (IFID_Reg1Used and IFID_SrcReg1==IDEX_DstReg) or (IFID_Reg2Used and IFID_SrcReg2==IDEX_DstReg).
REQ-007 Default outputs: PC_wen=1, IFID_wen=1, all others 0.
REQ-008 In RUN, events SHALL be evaluated in strict priority order: DMem_stall > LU > BranchTaken > Halt_ID > IMem_stall.
REQ-009 RUN with DMem_stall=1: PC_wen=0, IFID_wen=0, IDEX_stall=1, EXMEM_stall=1, MEMWB_stall=1; next state MEM_WAIT.
REQ-010 MEM_WAIT: same outputs as REQ-009 while DMem_stall=1; on the first cycle with DMem_stall=0, default outputs and next state RUN. Lower-priority events are ignored in MEM_WAIT.
REQ-011 RUN with LU (no DMem_stall): PC_wen=0, IFID_wen=0, IDEX_nop=1; exactly one bubble per hazard; BranchTaken and Halt_ID are suppressed in that cycle; state stays RUN.
REQ-012 RUN with BranchTaken (no higher event): PC_wen=1 and IFID_flush=1, regardless of IMem_stall.
REQ-013 RUN with Halt_ID (no higher event): PC_wen=0, IFID_flush=1; load the drain counter with 3; next state DRAIN.
REQ-014 RUN with IMem_stall only: PC_wen=0, IFID_flush=1.
REQ-015 DRAIN:
- Outputs: PC_wen=0, IFID_wen=0, IDEX_nop=1.
- The 2-bit drain counter decrements each cycle DMem_stall=0; at DMem_stall=1 it freezes, with EXMEM_stall=MEMWB_stall=1.
- When the counter reaches 0, next state HALTED.
REQ-016 HALTED: PC_wen=0, IFID_wen=0, IDEX_nop=1, halt_done=1; the block stays in HALTED until rst, and all inputs are ignored.
REQ-017 stall_cycles SHALL increment by 1 each cycle in RUN or MEM_WAIT with PC_wen=0; it does not count in DRAIN or HALTED; it saturates at 16'hFFFF with no wrap.
REQ-018 IDEX_stall and IDEX_nop SHALL never both be 1; IFID_wen and IFID_flush SHALL never both be 1.

Reset
REQ-019 rst=1 at a clock edge SHALL set state=RUN, drain counter=0, stall_cycles=0, halt_done=0; this takes effect from any state, including mid-MEM_WAIT and mid-DRAIN.
REQ-020 While rst=1, outputs SHALL take the RUN defaults with all hazard inputs ignored: PC_wen=1, IFID_wen=1, all other outputs 0.

Verification
REQ-021 Load-use: IDEX_MemRead=1, IDEX_DstReg=4'h3, IFID_SrcReg2=4'h3, IFID_Reg2Used=1, BranchTaken=1 -> that cycle PC_wen=0, IDEX_nop=1, IFID_flush=0, stall_cycles +1; the next cycle, with MemRead=0, defaults resume.
REQ-022 DstReg zero: same as REQ-021 but IDEX_DstReg=0, IFID_SrcReg2=0 -> no stall, PC_wen=1, IDEX_nop=0; BranchTaken acts, so IFID_flush=1.
REQ-023 Data memory wait: DMem_stall high for 4 cycles -> state RUN->MEM_WAIT for 4 cycles with all stall outputs 1, then RUN; stall_cycles=4.
REQ-024 Halt: Halt_ID=1 -> DRAIN for 3 cycles, then HALTED with halt_done=1; PC_wen stays 0 thereafter; rst returns the block to RUN with halt_done=0.
REQ-025 Stall saturation: preload via 65 535 stalled cycles, then 2 more -> stall_cycles=16'hFFFF, no wrap.
REQ-026 Reset mid-MEM_WAIT with DMem_stall still 1 -> next cycle state=RUN, stall_cycles=0; the block re-enters MEM_WAIT only on the cycle after rst deasserts.
